// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and stall decode for the pipeline sequencer.
// Stall vectors hold every stage upstream of (and including) the requesting stage.
package pipe_ctrl_pkg;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] CYC_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEFER = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // The deepest requesting stage wins: mem > ex > id.
  function automatic logic [5:0] stall_decode(input logic id, input logic ex, input logic mem);
    logic [5:0] v;
    v = STALL_NONE;
    if (mem)     v = STALL_MEM;
    else if (ex) v = STALL_EX;
    else if (id) v = STALL_ID;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Sequencer request/response bundle: stall requests and redirects in, stall/flush controls out.
// master drives requests (pipeline stages), slave is the sequencer.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc, perf_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc, perf_clr,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles; sets a sticky timeout once STALL_LIMIT is reached.
// Timeout registers on the STALL_LIMIT-th stalled edge; no backpressure, observe-only.
module pipe_ctrl_stall_watchdog #(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT - 1);

  logic [CNT_W-1:0] run_cnt;

  // Counter parks at CNT_MAX so a stuck pipeline cannot wrap and hide the expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else if (clear || !active) begin
      run_cnt <= '0;
    end else if (run_cnt == CNT_MAX) begin
      timeout <= 1'b1;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, turns redirects into a 1-cycle flush + new PC.
// Stall is combinational; flush/new_pc register one cycle after acceptance, deferred while MEM stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 10
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] stall_cycles_q;
  logic [5:0]  stall_vec;
  logic        flushing;

  assign flushing = (state_q == ST_FLUSH);

  // Held at zero during reset so no stage freezes on stale requests.
  always_comb begin
    stall_vec = STALL_NONE;
    if (rst && !flushing)
      stall_vec = stall_decode(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
  end

  always_comb begin
    state_d   = state_q;
    new_pc_d  = new_pc_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.flush_req) begin
          if (bus.stallreq_mem) begin
            state_d   = ST_DEFER;
            pend_pc_d = bus.flush_pc;
          end else begin
            state_d  = ST_FLUSH;
            new_pc_d = bus.flush_pc;
          end
        end
      end
      ST_DEFER: begin
        if (bus.flush_req)
          pend_pc_d = bus.flush_pc;
        if (!bus.stallreq_mem) begin
          state_d  = ST_FLUSH;
          new_pc_d = bus.flush_req ? bus.flush_pc : pend_pc_q;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_req) begin
          state_d  = ST_FLUSH;
          new_pc_d = bus.flush_pc;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      new_pc_q  <= RESET_PC;
      pend_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles_q <= '0;
    else if (bus.perf_clr)
      stall_cycles_q <= '0;
    else if (stall_vec[0] && (stall_cycles_q != CYC_MAX))
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  pipe_ctrl_stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (stall_vec != STALL_NONE),
    .clear   (flushing),
    .timeout (bus.stall_timeout)
  );

  assign bus.stall        = stall_vec;
  assign bus.flush        = flushing;
  assign bus.new_pc       = new_pc_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int LIMIT = 8;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a redirect is either flushing now, waiting behind MEM, or absent.
  bit          m_flush;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_new_pc;
  int          m_run;
  bit          m_to;
  longint      m_cyc;
  logic [5:0]  exp_stall;

  task automatic model_reset();
    m_flush = 0; m_pend = 0; m_pend_pc = '0; m_new_pc = '0;
    m_run = 0; m_to = 0; m_cyc = 0;
  endtask

  // Number of held stages counted from PC; a flush releases everything.
  function automatic logic [5:0] ref_stall();
    int n;
    n = bus.stallreq_mem ? 5 : bus.stallreq_ex ? 4 : bus.stallreq_id ? 3 : 0;
    if (m_flush) n = 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic drive(input logic id, input logic ex, input logic mem, input logic fr,
                       input logic [31:0] fpc, input logic clr);
    bus.stallreq_id = id; bus.stallreq_ex = ex; bus.stallreq_mem = mem;
    bus.flush_req = fr; bus.flush_pc = fpc; bus.perf_clr = clr;
    #1;
    exp_stall = ref_stall();
  endtask

  task automatic tick();
    bit nf;
    nf = 0;
    if (m_flush) begin
      if (bus.flush_req) begin nf = 1; m_new_pc = bus.flush_pc; end
    end else if (m_pend) begin
      if (!bus.stallreq_mem) begin
        nf = 1; m_pend = 0;
        m_new_pc = bus.flush_req ? bus.flush_pc : m_pend_pc;
      end else if (bus.flush_req) begin
        m_pend_pc = bus.flush_pc;
      end
    end else if (bus.flush_req) begin
      if (bus.stallreq_mem) begin m_pend = 1; m_pend_pc = bus.flush_pc; end
      else begin nf = 1; m_new_pc = bus.flush_pc; end
    end
    m_flush = nf;
    m_run = (exp_stall != 0) ? m_run + 1 : 0;
    if (m_run >= LIMIT) m_to = 1;
    if (bus.perf_clr) m_cyc = 0;
    else if (exp_stall[0] && m_cyc < CMAX) m_cyc = m_cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 32'hDEAD_BEEF, 0);
    checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b exp %b", bus.stall, 6'b0); end
    @(posedge clk); #1;
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
    checks++; if (bus.new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", bus.new_pc); end
    checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.stall_timeout); end
    checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_cycles got %h exp 0", bus.stall_cycles); end
    drive(0, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_watchdog();
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    for (int i = 0; i < LIMIT - 1; i++) begin drive(0, 1, 0, 0, 32'h0, 0); tick(); end
    checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_7 got %b exp 0", bus.stall_timeout); end
    drive(0, 1, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_8 got %b exp 1", bus.stall_timeout); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 32'h0, 0); tick(); end
    checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", bus.stall_timeout); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 1, 32'hA5A5_0000, 0); tick();
    drive(0, 0, 1, 1, 32'h1234_5670, 0); tick();
    drive(1, 1, 1, 0, 32'h0, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL rmid_stall got %b exp 0", bus.stall); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b exp 0", bus.flush); end
    checks++; if (bus.new_pc !== 32'h0) begin errors++; $display("FAIL rmid_new_pc got %h exp 0", bus.new_pc); end
    checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %b exp 0", bus.stall_timeout); end
    checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL rmid_cycles got %h exp 0", bus.stall_cycles); end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 32'h0, 0); tick();
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rmid_noflush[%0d] got %b exp 0", i, bus.flush); end
    end
  endtask

  task automatic test_stall_prio();
    drive(1, 0, 0, 0, 32'h0, 0);
    checks++; if (bus.stall !== 6'b000111) begin errors++; $display("FAIL prio_id got %b exp 000111", bus.stall); end
    tick();
    drive(1, 1, 0, 0, 32'h0, 0);
    checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL prio_ex got %b exp 001111", bus.stall); end
    tick();
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (bus.stall !== 6'b011111) begin errors++; $display("FAIL prio_mem got %b exp 011111", bus.stall); end
    tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL prio_flush got %b exp 0", bus.flush); end
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 32'h0, 0);
      checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL prio_rand[%0d] got %b exp %b", i, bus.stall, exp_stall); end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 1, 32'hBFC0_0380, 0); tick();
    drive(0, 0, 1, 0, 32'h0, 0);
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL flush_assert got %b exp 1", bus.flush); end
    checks++; if (bus.new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL flush_pc got %h exp bfc00380", bus.new_pc); end
    checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL flush_override got %b exp 0", bus.stall); end
    tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle got %b exp 0", bus.flush); end
    checks++; if (bus.stall !== 6'b011111) begin errors++; $display("FAIL flush_after_stall got %b exp 011111", bus.stall); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
  endtask

  task automatic test_defer();
    drive(0, 0, 1, 1, 32'h8000_0180, 0); tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL defer_c0 got %b exp 0", bus.flush); end
    drive(0, 0, 1, 1, 32'h8000_0200, 0); tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL defer_c1 got %b exp 0", bus.flush); end
    drive(0, 0, 1, 0, 32'h0, 0); tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL defer_c2 got %b exp 0", bus.flush); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL defer_release got %b exp 1", bus.flush); end
    checks++; if (bus.new_pc !== 32'h8000_0200) begin errors++; $display("FAIL defer_pc got %h exp 80000200", bus.new_pc); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL defer_done got %b exp 0", bus.flush); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 1, 32'h0040_1000, 0); tick();
    checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0040_1000) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/00401000", bus.flush, bus.new_pc); end
    drive(0, 0, 0, 1, 32'h0040_2000, 0); tick();
    checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0040_2000) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/00402000", bus.flush, bus.new_pc); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0040_2000) begin errors++; $display("FAIL b2b_hold got %b/%h exp 0/00402000", bus.flush, bus.new_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(99) < 25), 1'($urandom_range(99) < 20), 1'($urandom_range(99) < 30),
            1'($urandom_range(99) < 20), $urandom, 1'($urandom_range(99) < 5));
      checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, bus.stall, exp_stall); end
      tick();
      checks++; if (bus.flush !== m_flush) begin errors++; $display("FAIL rnd_flush[%0d] got %b exp %b", i, bus.flush, m_flush); end
      checks++; if (bus.new_pc !== m_new_pc) begin errors++; $display("FAIL rnd_new_pc[%0d] got %h exp %h", i, bus.new_pc, m_new_pc); end
      checks++; if (bus.stall_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout[%0d] got %b exp %b", i, bus.stall_timeout, m_to); end
      checks++; if (bus.stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL rnd_cycles[%0d] got %h exp %h", i, bus.stall_cycles, m_cyc[31:0]); end
    end
  endtask

  task automatic test_perf_sat();
    drive(1, 0, 0, 0, 32'h0, 0);
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    m_cyc = 64'h0000_0000_FFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL perf_sat[%0d] got %h exp %h", i, bus.stall_cycles, m_cyc[31:0]); end
      drive(1, 0, 0, 0, 32'h0, 0);
    end
    checks++; if (bus.stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_max got %h exp ffffffff", bus.stall_cycles); end
    drive(1, 0, 0, 0, 32'h0, 1); tick();
    checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL perf_clr got %h exp 0", bus.stall_cycles); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL perf_idle got %h exp 0", bus.stall_cycles); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_watchdog();
    test_reset_mid();
    test_stall_prio();
    test_flush();
    test_defer();
    test_back_to_back();
    test_random();
    test_perf_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
